// File: rtl/locked_reg_write_ctrl_if.sv
// Request / response / downstream write bundle for the locked register write controller.
// The master side issues requests and consumes responses; the slave side is the controller.
interface locked_reg_write_ctrl_if #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 2,
   parameter int CNT_W    = 8
);
   logic                req_valid;
   logic                req_ready;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_data;
   logic                req_lock;
   logic                req_trusted;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic [NUM_REGS-1:0] lock_status;
   logic                resp_valid;
   logic                resp_ready;
   logic                resp_err;
   logic [CNT_W-1:0]    viol_count;

   modport master (
      output req_valid, req_addr, req_data, req_lock, req_trusted, resp_ready,
      input  req_ready, wr_en, wr_addr, wr_data, lock_status, resp_valid, resp_err, viol_count
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_lock, req_trusted, resp_ready,
      output req_ready, wr_en, wr_addr, wr_data, lock_status, resp_valid, resp_err, viol_count
   );
endinterface

// File: rtl/locked_reg_write_ctrl.sv
// Write/lock sequencer in front of the locked data registers: owns sticky lock bits,
// forwards writes only to unlocked registers and counts rejected requests.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// CHECK | captured request is checked against address range, privilege and lock bits
// WRITE | one-cycle wr_en strobe to the downstream register
// RESP  | resp_valid held with resp_err until resp_ready
module locked_reg_write_ctrl #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 2,
   parameter int CNT_W    = 8
) (
   input  logic Clk,
   input  logic resetn,
   locked_reg_write_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                lock_req_q;
   logic                trusted_q;
   logic                req_ready_q;
   logic                wr_en_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [DATA_W-1:0]   wr_data_q;
   logic [NUM_REGS-1:0] lock_q;
   logic                resp_valid_q;
   logic                resp_err_q;
   logic [CNT_W-1:0]    viol_q;

   always_ff @(posedge Clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         lock_req_q   <= 1'b0;
         trusted_q    <= 1'b0;
         req_ready_q  <= 1'b1;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         lock_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         viol_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  addr_q      <= bus.req_addr;
                  data_q      <= bus.req_data;
                  lock_req_q  <= bus.req_lock;
                  trusted_q   <= bus.req_trusted;
                  req_ready_q <= 1'b0;
                  state_q     <= CHECK;
               end
            end
            CHECK: begin
               // Privilege never overrides a lock: a locked register rejects every write.
               if ((int'(addr_q) >= NUM_REGS) ||
                   (lock_req_q && !trusted_q) ||
                   (!lock_req_q && lock_q[addr_q])) begin
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  if (viol_q != {CNT_W{1'b1}}) begin
                     viol_q <= viol_q + CNT_W'(1);
                  end
                  state_q <= RESP;
               end else if (lock_req_q) begin
                  lock_q[addr_q] <= 1'b1;
                  resp_valid_q   <= 1'b1;
                  resp_err_q     <= 1'b0;
                  state_q        <= RESP;
               end else begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= addr_q;
                  wr_data_q <= data_q;
                  state_q   <= WRITE;
               end
            end
            WRITE: begin
               wr_en_q      <= 1'b0;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               state_q      <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.wr_en       = wr_en_q;
   assign bus.wr_addr     = wr_addr_q;
   assign bus.wr_data     = wr_data_q;
   assign bus.lock_status = lock_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_err    = resp_err_q;
   assign bus.viol_count  = viol_q;

endmodule
